control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset.
REQ-003 IR  input  32  current instruction register contents from datapath IR; fields opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-004 Stop  input  1  level; when 1 at a T0 boundary, sequencer halts.
REQ-005 PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout  output  1 each  bus-drive strobes.
REQ-006 MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, Zin_high, Zin_low, HIin, LOin  output  1 each  load/memory strobes.
REQ-007 Rin  output  16  one-hot-or-zero load enables, bit n drives RnIn.
REQ-008 Rout  output  16  one-hot-or-zero bus enables, bit n drives RnOut.
REQ-009 operation  output  4  ALU opCode.
REQ-010 Run  output  1  1 while sequencing, 0 in HALT.

Function
REQ-011 State register SHALL hold one of RST, T0..T7, HALT; all outputs are decoded from state and IR only (Moore, no input-to-output path except via IR).
REQ-012 Strobes not listed for a state SHALL be 0; at most one bus-drive source (Rout bit or *out strobe) SHALL be 1 in any state.
REQ-013 RST -> T0 on first edge after clear deasserts; no strobes in RST.
REQ-014 T0: PCout, MARin, IncPC, Zin_low. T1: Zlowout, PCin, Read, MDRin. T2: MDRout, IRin. T2 -> T3 always.
REQ-015 At T0 entry edge, if Stop=1 the next state SHALL be HALT instead of T0 strobes being issued.
REQ-016 R-type (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01001, ror 01010, rol 01011): T3 Rout[Rb], Yin; T4 Rout[Rc], operation, Zin_low; T5 Zlowout, Rin[Ra]; T5 -> T0.
REQ-017 Immediate (addi 01100, andi 01101, ori 01110): T3 Rout[Rb], Yin; T4 Cout, operation, Zin_low; T5 Zlowout, Rin[Ra]; T5 -> T0.
REQ-018 ld 00000: T3 Rout[Rb], Yin; T4 Cout, operation=ADD, Zin_low; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Rin[Ra]; T7 -> T0.
REQ-019 st 00010: T3-T5 as ld; T6 Rout[Ra], MDRin (Read=0); T7 Write; T7 -> T0.
REQ-020 mul 01111 / div 10000: T3 Rout[Ra], Yin; T4 Rout[Rb], operation, Zin_low, Zin_high; T5 Zlowout, LOin; T6 Zhighout, HIin; T6 -> T0.
REQ-021 halt 11011 -> HALT at T3; nop 11010 and any undefined opcode -> T0 at T3 with no strobes.
REQ-022 ALU opCode map: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, MUL 8, DIV 9; addi/andi/ori map to ADD/AND/OR.
REQ-023 HALT SHALL be absorbing (Run=0, all strobes 0) until clear asserts.
REQ-024 Rin/Rout index SHALL be the 4-bit field value; field 0 selects bit 0.

Reset
REQ-025 clear=0 SHALL force state RST immediately, regardless of clock; all strobes, Rin, Rout, operation = 0, Run = 0.
REQ-026 Reset mid-instruction SHALL abandon it; no partial Write/Rin pulse after clear asserts.
REQ-027 Run SHALL be 1 in every state except RST and HALT.

Structure
REQ-028 Shared package holds state encoding, 5-bit instruction opcodes and 4-bit ALU opCodes.
REQ-029 One sub-module, reg_decoder (4-bit field + enable -> 16-bit one-hot), instanced for Rin and Rout.

Verification
REQ-030 Release clear, IR=add R1,R2,R3 (0x18918000): T0-T5 sequence; T3 Rout=0x0004, T4 Rout=0x0008 operation=0, T5 Rin=0x0002; returns to T0.
REQ-031 IR=ld R4 via Rb=R5 (0x02280000): T5 MARin=1, T6 Read=MDRin=1, T7 Rin=0x0010; 8 cycles T0..T7.
REQ-032 IR=st R6 via Rb=R7 (0x13380000): T6 Rout=0x0040 MDRin=1 Read=0, T7 Write=1 single cycle.
REQ-033 IR=mul R2,R3 (0x79180000): T4 operation=8, Zin_low=Zin_high=1; T5 LOin; T6 HIin; back to T0.
REQ-034 IR=halt (0xD8000000) -> HALT, Run=0 held 20 cycles; Stop=1 at T0 -> HALT with no T0 strobes.
REQ-035 Assert clear during T4 of add: outputs zero asynchronously, state RST, no T5 Rin pulse.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encoding,
// instruction opcodes and ALU operation codes.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  // 5-bit instruction opcodes (IR[31:27])
  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01001;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;

  // ALU code for an opcode; memory ops compute their address with ADD
  function automatic logic [3:0] alu_code(input logic [4:0] opc);
    logic [3:0] code;
    code = ALU_ADD;
    case (opc)
      OPC_SUB:           code = ALU_SUB;
      OPC_AND, OPC_ANDI: code = ALU_AND;
      OPC_OR,  OPC_ORI:  code = ALU_OR;
      OPC_SHR:           code = ALU_SHR;
      OPC_SHL:           code = ALU_SHL;
      OPC_ROR:           code = ALU_ROR;
      OPC_ROL:           code = ALU_ROL;
      OPC_MUL:           code = ALU_MUL;
      OPC_DIV:           code = ALU_DIV;
      default:           code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// Register-field decoder: 4-bit register number plus enable to a
// one-hot (or all-zero) 16-bit select vector.
module reg_decoder
  import control_sequencer_pkg::*;
(
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  // One comparator per register select line
  for (genvar gi = 0; gi < 16; gi++) begin : g_sel
    assign onehot[gi] = en && (field == 4'(gi));
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for a simple CPU datapath: fetch (T0-T2),
// then opcode-dependent execute steps (T3-T7), with HALT as a sink.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Zin_high,
  output logic        Zin_low,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0]  operation,
  output logic        Run
);

  state_t     state_reg, state_next;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       is_rtype, is_imm, is_ld, is_st, is_md, is_halt;
  logic [3:0] rin_sel, rout_sel;
  logic       rin_en, rout_en;
  logic       ir_unused;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign ir_unused = ^IR[14:0];

  // Classify the opcode into the execute-phase families
  always_comb begin
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_ld    = (opc == OPC_LD);
    is_st    = (opc == OPC_ST);
    is_md    = (opc == OPC_MUL) || (opc == OPC_DIV);
    is_halt  = (opc == OPC_HALT);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: is_rtype = 1'b1;
      OPC_ADDI, OPC_ANDI, OPC_ORI:        is_imm   = 1'b1;
      default: ;
    endcase
  end

  // State register; clear drops straight back to RST
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_reg <= ST_RST;
    else        state_reg <= state_next;
  end

  // Next-state and strobe decode; every T0 entry is diverted to HALT by Stop
  always_comb begin
    state_next = state_reg;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; Zin_high = 1'b0;
    Zin_low = 1'b0; HIin = 1'b0; LOin = 1'b0;
    operation = ALU_ADD;
    rin_en = 1'b0; rin_sel = ra;
    rout_en = 1'b0; rout_sel = ra;
    Run = (state_reg != ST_RST) && (state_reg != ST_HALT);
    case (state_reg)
      ST_RST: state_next = Stop ? ST_HALT : ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
        state_next = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = ST_T3;
      end
      ST_T3: begin
        if (is_rtype || is_imm || is_ld || is_st) begin
          rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
          state_next = ST_T4;
        end else if (is_md) begin
          rout_en = 1'b1; rout_sel = ra; Yin = 1'b1;
          state_next = ST_T4;
        end else if (is_halt) begin
          state_next = ST_HALT;
        end else begin
          state_next = Stop ? ST_HALT : ST_T0;
        end
      end
      ST_T4: begin
        Zin_low = 1'b1;
        operation = alu_code(opc);
        if (is_rtype) begin
          rout_en = 1'b1; rout_sel = rc;
        end else if (is_md) begin
          rout_en = 1'b1; rout_sel = rb; Zin_high = 1'b1;
        end else begin
          Cout = 1'b1;
        end
        state_next = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (is_rtype || is_imm) begin
          rin_en = 1'b1;
          state_next = Stop ? ST_HALT : ST_T0;
        end else if (is_md) begin
          LOin = 1'b1;
          state_next = ST_T6;
        end else begin
          MARin = 1'b1;
          state_next = ST_T6;
        end
      end
      ST_T6: begin
        if (is_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
          state_next = Stop ? ST_HALT : ST_T0;
        end else if (is_st) begin
          rout_en = 1'b1; MDRin = 1'b1;
          state_next = ST_T7;
        end else begin
          Read = 1'b1; MDRin = 1'b1;
          state_next = ST_T7;
        end
      end
      ST_T7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1; rin_en = 1'b1;
        end
        state_next = Stop ? ST_HALT : ST_T0;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
  end

  reg_decoder u_rin_dec (
    .field  (rin_sel),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_decoder u_rout_dec (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer. A reference model
// expands each instruction into its list of per-cycle output words.
module tb_control_sequencer;

  typedef struct packed {
    logic        run;
    logic [3:0]  op;
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, c_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, rd, wr;
    logic zhi_in, zlo_in, hi_in, lo_in;
  } outs_t;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        Stop = 1'b0;
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Write;
  logic Zin_high, Zin_low, HIin, LOin, Run;
  logic [15:0] Rin, Rout;
  logic [3:0]  operation;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .Cout(Cout), .MARin(MARin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .Zin_high(Zin_high), .Zin_low(Zin_low),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .operation(operation), .Run(Run)
  );

  always #5 Clock = ~Clock;

  outs_t dut_o;
  assign dut_o = {Run, operation, Rin, Rout, PCout, Zlowout, Zhighout, HIout,
                  LOout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, IncPC,
                  Read, Write, Zin_high, Zin_low, HIin, LOin};

  int checks = 0;
  int errors = 0;

  typedef enum {M_RST, M_NEW, M_SEQ, M_HALT} mode_t;
  mode_t       mode = M_RST;
  outs_t       q[$];
  logic        halt_after = 1'b0;
  int          step = 0;
  logic [31:0] next_ir = 32'h0;
  logic [31:0] cur_ir = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d ir=%h got=%h want=%h", name, step, cur_ir, act, exp);
    end
  endtask

  // Expand one instruction into the expected output word of each cycle
  task automatic build_seq(input logic [31:0] ir);
    outs_t b, s;
    int opc, ra, rb, rc, alu, kind;
    opc = int'(ir[31:27]); ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);  rc = int'(ir[18:15]);
    // kind: 0 nop/undefined, 1 r-type, 2 immediate, 3 ld, 4 st, 5 mul/div, 6 halt
    kind = 0; alu = 0;
    case (opc)
      3: begin kind = 1; alu = 0; end
      4: begin kind = 1; alu = 1; end
      5: begin kind = 1; alu = 2; end
      6: begin kind = 1; alu = 3; end
      7: begin kind = 1; alu = 4; end
      9: begin kind = 1; alu = 5; end
      10: begin kind = 1; alu = 6; end
      11: begin kind = 1; alu = 7; end
      12: begin kind = 2; alu = 0; end
      13: begin kind = 2; alu = 2; end
      14: begin kind = 2; alu = 3; end
      0: kind = 3;
      2: kind = 4;
      15: begin kind = 5; alu = 8; end
      16: begin kind = 5; alu = 9; end
      27: kind = 6;
      default: kind = 0;
    endcase
    q.delete();
    halt_after = (kind == 6);
    b = '0; b.run = 1'b1;
    s = b; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zlo_in = 1; q.push_back(s);
    s = b; s.zlo_out = 1; s.pc_in = 1; s.rd = 1; s.mdr_in = 1; q.push_back(s);
    s = b; s.mdr_out = 1; s.ir_in = 1; q.push_back(s);
    if (kind == 0 || kind == 6) begin
      q.push_back(b);
    end else if (kind == 5) begin
      s = b; s.rout = 16'(1 << ra); s.y_in = 1; q.push_back(s);
      s = b; s.rout = 16'(1 << rb); s.op = 4'(alu); s.zlo_in = 1; s.zhi_in = 1; q.push_back(s);
      s = b; s.zlo_out = 1; s.lo_in = 1; q.push_back(s);
      s = b; s.zhi_out = 1; s.hi_in = 1; q.push_back(s);
    end else begin
      s = b; s.rout = 16'(1 << rb); s.y_in = 1; q.push_back(s);
      s = b; s.op = 4'(alu); s.zlo_in = 1;
      if (kind == 1) s.rout = 16'(1 << rc); else s.c_out = 1;
      q.push_back(s);
      s = b; s.zlo_out = 1;
      if (kind <= 2) s.rin = 16'(1 << ra); else s.mar_in = 1;
      q.push_back(s);
      if (kind == 3) begin
        s = b; s.rd = 1; s.mdr_in = 1; q.push_back(s);
        s = b; s.mdr_out = 1; s.rin = 16'(1 << ra); q.push_back(s);
      end else if (kind == 4) begin
        s = b; s.rout = 16'(1 << ra); s.mdr_in = 1; q.push_back(s);
        s = b; s.wr = 1; q.push_back(s);
      end
    end
  endtask

  // Advance one clock and compare every output against the model
  task automatic tick();
    outs_t exp;
    if (mode == M_RST || (mode == M_SEQ && q.size() == 0)) begin
      if (mode == M_SEQ && halt_after) mode = M_HALT;
      else if (Stop)                   mode = M_HALT;
      else                             mode = M_NEW;
    end
    @(posedge Clock); #1;
    if (mode == M_NEW) begin
      IR = next_ir; cur_ir = next_ir;
      build_seq(next_ir);
      mode = M_SEQ; step = 0;
    end else if (mode == M_SEQ) begin
      step++;
    end
    exp = (mode == M_SEQ) ? q.pop_front() : '0;
    #1;
    chk("cycle", 64'(dut_o), 64'(exp));
  endtask

  task automatic apply_reset();
    clear = 1'b0;
    #1;
    chk("clr_async", 64'(dut_o), 64'h0);
    mode = M_RST; q.delete(); halt_after = 1'b0;
    repeat (2) begin
      @(posedge Clock); #1;
      chk("clr_hold", 64'(dut_o), 64'h0);
    end
    clear = 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] opc;
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 2)       opc = 5'b11011;
    else if (sel < 12) opc = 5'($urandom_range(0, 31));
    else begin
      case ($urandom_range(0, 15))
        0: opc = 5'd0;   1: opc = 5'd2;   2: opc = 5'd3;   3: opc = 5'd4;
        4: opc = 5'd5;   5: opc = 5'd6;   6: opc = 5'd7;   7: opc = 5'd9;
        8: opc = 5'd10;  9: opc = 5'd11;  10: opc = 5'd12; 11: opc = 5'd13;
        12: opc = 5'd14; 13: opc = 5'd15; 14: opc = 5'd16; default: opc = 5'd26;
      endcase
    end
    return {opc, 27'($urandom)};
  endfunction

  initial begin
    int halt_cnt;
    #2;
    apply_reset();

    // add R1,R2,R3
    next_ir = 32'h18918000;
    for (int i = 0; i < 6; i++) begin
      tick();
      case (i)
        0: chk("add_t0_pcout", 64'(PCout), 64'h1);
        3: chk("add_t3_rout", 64'(Rout), 64'h0004);
        4: begin
          chk("add_t4_rout", 64'(Rout), 64'h0008);
          chk("add_t4_op", 64'(operation), 64'h0);
        end
        5: chk("add_t5_rin", 64'(Rin), 64'h0002);
        default: ;
      endcase
    end

    // ld R4 via R5, 8 cycles
    next_ir = 32'h02280000;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i)
        5: chk("ld_t5_marin", 64'(MARin), 64'h1);
        6: chk("ld_t6_rd_mdr", 64'({Read, MDRin}), 64'h3);
        7: chk("ld_t7_rin", 64'(Rin), 64'h0010);
        default: ;
      endcase
    end

    // st R6 via R7
    next_ir = 32'h13380000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) chk("ld_len_back_t0", 64'({IncPC, Run}), 64'h3);
      if (i == 6) chk("st_t6", 64'({Rout, MDRin, Read}), {46'h0, 16'h0040, 2'b10});
      if (i == 7) chk("st_t7_write", 64'(Write), 64'h1);
    end

    // mul R2,R3
    next_ir = 32'h79180000;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) chk("st_write_single", 64'(Write), 64'h0);
      if (i == 4) chk("mul_t4", 64'({operation, Zin_low, Zin_high}), 64'h23);
      if (i == 5) chk("mul_t5_loin", 64'(LOin), 64'h1);
      if (i == 6) chk("mul_t6_hiin", 64'(HIin), 64'h1);
    end

    // halt: four fetch/decode cycles, then absorbed
    next_ir = 32'hD8000000;
    for (int i = 0; i < 4; i++) tick();
    chk("mul_back_len", 64'(mode == M_SEQ), 64'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_run", 64'(Run), 64'h0);
    end

    // Stop at the T0 boundary goes straight to HALT
    apply_reset();
    Stop = 1'b1;
    tick();
    chk("stop_no_t0", 64'({Run, PCout, MARin, IncPC}), 64'h0);
    Stop = 1'b0;
    tick();

    // clear during T4 of add abandons it
    apply_reset();
    next_ir = 32'h18918000;
    for (int i = 0; i < 5; i++) tick();
    chk("add_t4_reached", 64'(Zin_low), 64'h1);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) chk("clr_restart_t0", 64'(PCout), 64'h1);
    end

    // Randomized run
    halt_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      next_ir = rand_ir();
      Stop = ($urandom_range(0, 24) == 0);
      tick();
      if (mode == M_HALT) halt_cnt++;
      if (halt_cnt > 3 || $urandom_range(0, 299) == 0) begin
        halt_cnt = 0;
        Stop = 1'b0;
        apply_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
